// File: rtl/csr_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : csr_regfile
//  Purpose  : LoongArch control/status register file. Absorbs writeback-stage
//             exception/ertn commits, serves csrrd/csrwr/csrxchg accesses,
//             raises the interrupt-pending flag and hosts the constant timer.
//  Revision : 1.0 - initial release
// ============================================================================
module csr_regfile #(
    parameter int          TIMER_W = 32,
    parameter logic [31:0] TID_RST = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry,
    output logic        has_int
);

    localparam logic [13:0] c_crmd   = 14'h000;
    localparam logic [13:0] c_prmd   = 14'h001;
    localparam logic [13:0] c_ecfg   = 14'h004;
    localparam logic [13:0] c_estat  = 14'h005;
    localparam logic [13:0] c_era    = 14'h006;
    localparam logic [13:0] c_badv   = 14'h007;
    localparam logic [13:0] c_eentry = 14'h00C;
    localparam logic [13:0] c_save0  = 14'h030;
    localparam logic [13:0] c_save1  = 14'h031;
    localparam logic [13:0] c_save2  = 14'h032;
    localparam logic [13:0] c_save3  = 14'h033;
    localparam logic [13:0] c_tid    = 14'h040;
    localparam logic [13:0] c_tcfg   = 14'h041;
    localparam logic [13:0] c_tval   = 14'h042;
    localparam logic [13:0] c_ticlr  = 14'h044;

    localparam logic [5:0]  c_ecode_adef = 6'h08;
    localparam logic [5:0]  c_ecode_ale  = 6'h09;

    logic [1:0]          r_crmd_plv;
    logic                r_crmd_ie;
    logic                r_crmd_da;
    logic                r_crmd_pg;
    logic [1:0]          r_crmd_datf;
    logic [1:0]          r_crmd_datm;
    logic [1:0]          r_prmd_pplv;
    logic                r_prmd_pie;
    logic [11:0]         r_ecfg_lie;      // {LIE[12:11], LIE[9:0]}
    logic [1:0]          r_is_sw;
    logic [7:0]          r_is_hw;
    logic                r_is_ti;
    logic                r_is_ipi;
    logic [5:0]          r_ecode;
    logic [8:0]          r_esubcode;
    logic [31:0]         r_era;
    logic [31:0]         r_badv;
    logic [25:0]         r_eentry_va;
    logic [31:0]         r_save [4];
    logic [31:0]         r_tid;
    logic                r_tcfg_en;
    logic                r_tcfg_periodic;
    logic [TIMER_W-3:0]  r_tcfg_initval;
    logic [TIMER_W-1:0]  r_timer;

    logic [12:0]         w_is;
    logic [12:0]         w_lie;
    logic [31:0]         w_tcfg;
    logic [31:0]         w_tval;
    logic [31:0]         w_wdata;
    logic                w_wr;
    logic                w_tcfg_load;
    logic                w_timer_fire;
    logic                w_ticlr;
    logic                w_unused;

    assign w_unused = csr_re;

    assign w_is  = {r_is_ipi, r_is_ti, 1'b0, r_is_hw, r_is_sw};
    assign w_lie = {r_ecfg_lie[11:10], 1'b0, r_ecfg_lie[9:0]};

    // Zero-extend the timer-width fields into 32-bit read views
    always_comb begin
        w_tcfg                = '0;
        w_tcfg[TIMER_W-1:2]   = r_tcfg_initval;
        w_tcfg[1]             = r_tcfg_periodic;
        w_tcfg[0]             = r_tcfg_en;
        w_tval                = '0;
        w_tval[TIMER_W-1:0]   = r_timer;
    end

    // Combinational read mux; unknown addresses and reserved bits read 0
    always_comb begin
        csr_rvalue = '0;
        case (csr_num)
            c_crmd:   csr_rvalue = {23'b0, r_crmd_datm, r_crmd_datf, r_crmd_pg,
                                    r_crmd_da, r_crmd_ie, r_crmd_plv};
            c_prmd:   csr_rvalue = {29'b0, r_prmd_pie, r_prmd_pplv};
            c_ecfg:   csr_rvalue = {19'b0, w_lie};
            c_estat:  csr_rvalue = {1'b0, r_esubcode, r_ecode, 3'b0, w_is};
            c_era:    csr_rvalue = r_era;
            c_badv:   csr_rvalue = r_badv;
            c_eentry: csr_rvalue = {r_eentry_va, 6'b0};
            c_save0:  csr_rvalue = r_save[0];
            c_save1:  csr_rvalue = r_save[1];
            c_save2:  csr_rvalue = r_save[2];
            c_save3:  csr_rvalue = r_save[3];
            c_tid:    csr_rvalue = r_tid;
            c_tcfg:   csr_rvalue = w_tcfg;
            c_tval:   csr_rvalue = w_tval;
            default:  csr_rvalue = '0;
        endcase
    end

    // The old value is the current read value, so masking merges against it;
    // exception and ertn commits take precedence over software writes.
    assign w_wdata      = (csr_rvalue & ~csr_wmask) | (csr_wvalue & csr_wmask);
    assign w_wr         = csr_we & ~wb_ex & ~ertn_flush;
    assign w_tcfg_load  = w_wr && (csr_num == c_tcfg) && w_wdata[0];
    assign w_timer_fire = !w_tcfg_load && r_tcfg_en && (r_timer == '0);
    assign w_ticlr      = w_wr && (csr_num == c_ticlr) && w_wdata[0];

    // CRMD/PRMD: exception entry saves and clears, ertn restores
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_crmd_plv  <= 2'b0;
            r_crmd_ie   <= 1'b0;
            r_crmd_da   <= 1'b1;
            r_crmd_pg   <= 1'b0;
            r_crmd_datf <= 2'b0;
            r_crmd_datm <= 2'b0;
            r_prmd_pplv <= 2'b0;
            r_prmd_pie  <= 1'b0;
        end else if (wb_ex) begin
            r_prmd_pplv <= r_crmd_plv;
            r_prmd_pie  <= r_crmd_ie;
            r_crmd_plv  <= 2'b0;
            r_crmd_ie   <= 1'b0;
        end else if (ertn_flush) begin
            r_crmd_plv  <= r_prmd_pplv;
            r_crmd_ie   <= r_prmd_pie;
        end else if (w_wr && csr_num == c_crmd) begin
            r_crmd_plv  <= w_wdata[1:0];
            r_crmd_ie   <= w_wdata[2];
            r_crmd_da   <= w_wdata[3];
            r_crmd_pg   <= w_wdata[4];
            r_crmd_datf <= w_wdata[6:5];
            r_crmd_datm <= w_wdata[8:7];
        end else if (w_wr && csr_num == c_prmd) begin
            r_prmd_pplv <= w_wdata[1:0];
            r_prmd_pie  <= w_wdata[2];
        end
    end

    // Exception record (ESTAT code fields, ERA, BADV) and plain storage CSRs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ecode     <= 6'b0;
            r_esubcode  <= 9'b0;
            r_era       <= 32'b0;
            r_badv      <= 32'b0;
            r_ecfg_lie  <= 12'b0;
            r_is_sw     <= 2'b0;
            r_eentry_va <= 26'b0;
            r_tid       <= TID_RST;
            for (int i = 0; i < 4; i++) r_save[i] <= 32'b0;
        end else if (wb_ex) begin
            r_ecode    <= wb_ecode;
            r_esubcode <= wb_esubcode;
            r_era      <= wb_pc;
            if (wb_ecode == c_ecode_adef && wb_esubcode == 9'b0)
                r_badv <= wb_pc;
            else if (wb_ecode == c_ecode_ale)
                r_badv <= wb_vaddr;
        end else if (w_wr) begin
            case (csr_num)
                c_ecfg:   r_ecfg_lie  <= {w_wdata[12:11], w_wdata[9:0]};
                c_estat:  r_is_sw     <= w_wdata[1:0];
                c_era:    r_era       <= w_wdata;
                c_badv:   r_badv      <= w_wdata;
                c_eentry: r_eentry_va <= w_wdata[31:6];
                c_save0:  r_save[0]   <= w_wdata;
                c_save1:  r_save[1]   <= w_wdata;
                c_save2:  r_save[2]   <= w_wdata;
                c_save3:  r_save[3]   <= w_wdata;
                c_tid:    r_tid       <= w_wdata;
                default:  ;
            endcase
        end
    end

    // Interrupt lines sampled every cycle; timer interrupt set beats TICLR
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_is_hw  <= 8'b0;
            r_is_ipi <= 1'b0;
            r_is_ti  <= 1'b0;
        end else begin
            r_is_hw  <= hw_int_in;
            r_is_ipi <= ipi_int_in;
            if (w_timer_fire)
                r_is_ti <= 1'b1;
            else if (w_ticlr)
                r_is_ti <= 1'b0;
        end
    end

    // Timer config and counter: load on enabling write, else count down
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tcfg_en       <= 1'b0;
            r_tcfg_periodic <= 1'b0;
            r_tcfg_initval  <= '0;
            r_timer         <= '1;
        end else begin
            if (w_wr && csr_num == c_tcfg) begin
                r_tcfg_en       <= w_wdata[0];
                r_tcfg_periodic <= w_wdata[1];
                r_tcfg_initval  <= w_wdata[TIMER_W-1:2];
            end
            if (w_tcfg_load)
                r_timer <= {w_wdata[TIMER_W-1:2], 2'b00};
            else if (r_tcfg_en && !(&r_timer)) begin
                if (r_timer == '0 && r_tcfg_periodic)
                    r_timer <= {r_tcfg_initval, 2'b00};
                else
                    r_timer <= r_timer - TIMER_W'(1);
            end
        end
    end

    assign has_int    = r_crmd_ie & (|(w_is & w_lie));
    assign ex_entry   = {r_eentry_va, 6'b0};
    assign ertn_entry = r_era;

endmodule
`default_nettype wire

// File: tb/tb_csr_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_regfile
//  Purpose  : Directed self-checking bench for csr_regfile
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csr_regfile;

    logic        clk = 1'b0;
    logic        resetn;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        has_int;

    int n_tests = 0;
    int n_fail  = 0;

    csr_regfile #(.TIMER_W(32), .TID_RST(32'h0)) dut (
        .clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_num(csr_num),
        .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
        .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .ertn_flush(ertn_flush), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .ex_entry(ex_entry), .ertn_entry(ertn_entry), .has_int(has_int)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [13:0] n, input logic [31:0] exp);
        csr_num = n;
        #1;
        chk(tag, csr_rvalue, exp);
    endtask

    task automatic csr_wr(input logic [13:0] n, input logic [31:0] m, input logic [31:0] v);
        csr_we = 1'b1; csr_num = n; csr_wmask = m; csr_wvalue = v;
        step();
        csr_we = 1'b0;
    endtask

    task automatic pulse_ex(input logic [5:0] ec, input logic [8:0] esc,
                            input logic [31:0] pc, input logic [31:0] va);
        wb_ex = 1'b1; wb_ecode = ec; wb_esubcode = esc; wb_pc = pc; wb_vaddr = va;
        step();
        wb_ex = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; csr_re = 1'b1; csr_num = '0; csr_we = 1'b0;
        csr_wmask = '0; csr_wvalue = '0; wb_ex = 1'b0; wb_ecode = '0;
        wb_esubcode = '0; wb_pc = '0; wb_vaddr = '0; ertn_flush = 1'b0;
        hw_int_in = '0; ipi_int_in = 1'b0;
        step(); step();
        resetn = 1'b1;

        // Reset state
        rd_chk("rst_crmd", 14'h000, 32'h0000_0008);
        rd_chk("rst_era", 14'h006, 32'h0);
        rd_chk("rst_estat", 14'h005, 32'h0);
        rd_chk("rst_ecfg", 14'h004, 32'h0);
        rd_chk("rst_tval", 14'h042, 32'hFFFF_FFFF);
        chk("rst_has_int", {31'b0, has_int}, 32'h0);
        chk("rst_ex_entry", ex_entry, 32'h0);
        chk("rst_ertn_entry", ertn_entry, 32'h0);

        // Masked write, read-old-during-write, unmapped address
        csr_wr(14'h031, 32'hFFFF_FFFF, 32'hAAAA_AAAA);
        csr_we = 1'b1; csr_num = 14'h031; csr_wmask = 32'hFFFF_0000; csr_wvalue = 32'h1234_5678;
        #1;
        chk("save1_read_old", csr_rvalue, 32'hAAAA_AAAA);
        step();
        csr_we = 1'b0;
        rd_chk("save1_masked", 14'h031, 32'h1234_AAAA);
        csr_wr(14'h099, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        rd_chk("unmapped_0x99", 14'h099, 32'h0);

        // Exception entry (ALE) from PLV3/IE1
        csr_wr(14'h000, 32'h0000_0007, 32'h0000_0007);
        rd_chk("crmd_plv3_ie", 14'h000, 32'h0000_000F);
        pulse_ex(6'h09, 9'h0, 32'h1C00_0100, 32'h0000_1003);
        rd_chk("ex_prmd", 14'h001, 32'h0000_0007);
        rd_chk("ex_crmd", 14'h000, 32'h0000_0008);
        rd_chk("ex_era", 14'h006, 32'h1C00_0100);
        rd_chk("ex_badv_ale", 14'h007, 32'h0000_1003);
        rd_chk("ex_estat", 14'h005, 32'h0009_0000);
        chk("ex_ertn_entry", ertn_entry, 32'h1C00_0100);

        // ertn restores PLV/IE, PRMD untouched
        ertn_flush = 1'b1;
        step();
        ertn_flush = 1'b0;
        rd_chk("ertn_crmd", 14'h000, 32'h0000_000F);
        rd_chk("ertn_prmd", 14'h001, 32'h0000_0007);

        // Exception (ADEF) together with a CRMD write: write dropped
        csr_we = 1'b1; csr_num = 14'h000; csr_wmask = 32'h7; csr_wvalue = 32'h7;
        pulse_ex(6'h08, 9'h0, 32'h1C00_0200, 32'h0000_5555);
        csr_we = 1'b0;
        rd_chk("exwe_crmd", 14'h000, 32'h0000_0008);
        rd_chk("adef_badv", 14'h007, 32'h1C00_0200);

        // Other ecode leaves BADV alone
        pulse_ex(6'h0B, 9'h0, 32'h1C00_0300, 32'h0000_7777);
        rd_chk("sys_badv", 14'h007, 32'h1C00_0200);
        rd_chk("sys_estat", 14'h005, 32'h000B_0000);

        // Reserved bits of EENTRY and ECFG
        csr_wr(14'h00C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd_chk("eentry_rd", 14'h00C, 32'hFFFF_FFC0);
        chk("ex_entry", ex_entry, 32'hFFFF_FFC0);
        csr_wr(14'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd_chk("ecfg_rsvd", 14'h004, 32'h0000_1BFF);
        rd_chk("tid_rst", 14'h040, 32'h0);

        // Periodic timer: InitVal=2 -> 8,7,...,0 then fire and reload
        csr_wr(14'h000, 32'h4, 32'h4);
        csr_wr(14'h004, 32'hFFFF_FFFF, 32'h0000_0800);
        csr_wr(14'h041, 32'hFFFF_FFFF, 32'h0000_000B);
        rd_chk("tcfg_rd", 14'h041, 32'h0000_000B);
        rd_chk("tval_load", 14'h042, 32'h8);
        for (int k = 7; k >= 0; k--) begin
            step();
            rd_chk($sformatf("tval_%0d", k), 14'h042, 32'(k));
        end
        chk("pre_fire_has_int", {31'b0, has_int}, 32'h0);
        step();
        rd_chk("tval_reload", 14'h042, 32'h8);
        rd_chk("ti_set_estat", 14'h005, 32'h000B_0800);
        chk("ti_has_int", {31'b0, has_int}, 32'h1);
        csr_wr(14'h044, 32'h1, 32'h1);
        rd_chk("ticlr_estat", 14'h005, 32'h000B_0000);
        chk("ticlr_has_int", {31'b0, has_int}, 32'h0);
        rd_chk("ticlr_rd0", 14'h044, 32'h0);

        // Disable: counter holds
        csr_wr(14'h041, 32'hFFFF_FFFF, 32'h0);
        step(); step();
        rd_chk("tval_hold", 14'h042, 32'h6);

        // One-shot timer: InitVal=1 -> 4..0, fire, park at all ones
        csr_wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0005);
        step(); step(); step(); step();
        rd_chk("oneshot_zero", 14'h042, 32'h0);
        step();
        rd_chk("oneshot_ones", 14'h042, 32'hFFFF_FFFF);
        rd_chk("oneshot_ti", 14'h005, 32'h000B_0800);
        step();
        rd_chk("oneshot_stop", 14'h042, 32'hFFFF_FFFF);
        csr_wr(14'h044, 32'h1, 32'h1);
        rd_chk("oneshot_clr", 14'h005, 32'h000B_0000);

        // Hardware interrupt line 0 -> IS[2]
        csr_wr(14'h004, 32'hFFFF_FFFF, 32'h0000_0004);
        hw_int_in = 8'h01;
        #1;
        chk("hw_immediate", {31'b0, has_int}, 32'h0);
        step(); step();
        chk("hw_has_int", {31'b0, has_int}, 32'h1);
        rd_chk("hw_estat", 14'h005, 32'h000B_0004);
        hw_int_in = 8'h00;
        step(); step();
        chk("hw_drop", {31'b0, has_int}, 32'h0);

        // IE gates interrupts
        hw_int_in = 8'h01;
        csr_wr(14'h000, 32'h4, 32'h0);
        step();
        chk("ie_gate", {31'b0, has_int}, 32'h0);
        hw_int_in = 8'h00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
